cpu_run_monitor: RTL
====================

Name: cpu_run_monitor

Overview:
Parametrised, synthesizable run controller and result checker for the multicycle MIPS core. It replaces fixed-delay, fixed-register end-of-test checking. The block counts cycles and fetched instructions, detects program halt (a jump-to-self loop), enforces a cycle timeout, and snapshots N register taps to compare them against expected values. It sits beside cpu, fed from fetch/PC and regfile taps; the bench reads only its status outputs.

Parameters:
DATA_WIDTH, 32, width of each checked register tap
ADDR_WIDTH, 32, width of fetch PC
CYCLE_WIDTH, 17, width of cycle and instruction counters (saturating)
TIMEOUT, 4096, RUN cycles before forced stop; 1 <= TIMEOUT <= 2^CYCLE_WIDTH-1
HALT_REPEAT, 2, consecutive fetches at an identical PC that declare halt; >= 2
NUM_CHECKS, 3, number of register check channels

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a run (level sampled per clk)
fetch_valid  in  1  one-cycle pulse when IR is loaded
fetch_pc  in  ADDR_WIDTH  PC of the fetched instruction
chk_data  in  NUM_CHECKS*DATA_WIDTH  flattened regfile taps, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
chk_expect  in  NUM_CHECKS*DATA_WIDTH  expected values, same packing
chk_enable  in  NUM_CHECKS  per-channel compare enable
busy  out  1  in RUN or CAPTURE
done  out  1  in DONE
halted  out  1  run ended by halt detection
timed_out  out  1  run ended by timeout
pass  out  1  halted and no enabled mismatch
fail_mask  out  NUM_CHECKS  enabled channels that mismatched
cycle_count  out  CYCLE_WIDTH  RUN cycles elapsed
instr_count  out  CYCLE_WIDTH  fetch_valid pulses seen in RUN
snap_data  out  NUM_CHECKS*DATA_WIDTH  captured chk_data

Behaviour:
- Reset (async, reset_n=0): state IDLE. Every output and internal register is 0: counters, last_pc, repeat_cnt, snap_data, fail_mask, halted, timed_out, pass. Reset mid-run aborts immediately, with no capture.
- FSM states: IDLE, RUN, CAPTURE, DONE.
- IDLE: start=1 leads to RUN on the next edge. On that edge, clear counters, repeat_cnt, pc_seen, halted, timed_out, pass, fail_mask and snap_data.
- RUN, each edge:
  - cycle_count increments and saturates at all-ones.
  - If fetch_valid=1: instr_count increments (saturating).
  - If pc_seen and fetch_pc==last_pc, repeat_cnt increments; otherwise repeat_cnt is set to 1.
  - On every fetch: last_pc<=fetch_pc and pc_seen<=1.
  - fetch_valid=0 leaves last_pc and repeat_cnt unchanged.
- Halt condition: a fetch that makes the repeat count reach HALT_REPEAT. This edge sets halted=1 and moves to CAPTURE; the counters include that fetch.
- Timeout condition: in RUN with cycle_count==TIMEOUT-1 and no halt this edge. Sets timed_out=1 and moves to CAPTURE, so cycle_count==TIMEOUT.
- Halt and timeout on the same edge: halt wins, halted=1, timed_out=0.
- start is ignored in RUN and CAPTURE.
- CAPTURE (exactly 1 cycle): snap_data<=chk_data. For each channel i, fail_mask[i]<=chk_enable[i] & (chk_data_i != chk_expect_i). Next state DONE. Counters are frozen.
- DONE: done=1 and pass=halted & ~|fail_mask. All results hold until reset or start. start=1 in DONE restarts RUN with the same clearing as from IDLE.
- busy=1 in RUN and CAPTURE only. done and busy are never both 1.
- Latency: halting fetch edge to done=1 is 2 edges.

Decomposition:
- Package cpu_run_monitor_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2, DONE=2'd3);
  - a function returning the flattened-slice base index.
- Sub-module check_lane, instantiated NUM_CHECKS times via generate. Per channel it holds the snapshot register and the mismatch flag, with a capture strobe and a clear input.
- Top level holds the FSM, counters and halt detector.

Test Plan:
- Halt, default params: start; fetch pulses every 4 cycles at PC 0,4,8,12,12. Expect halted=1, timed_out=0, instr_count=5, done 2 edges after the fifth fetch.
- Check pass/fail, NUM_CHECKS=3, chk_enable=3'b111, expect {t0=5, t1=7, v0=12}, actual v0=11. Expect fail_mask=3'b100, pass=0, snap_data channel 2 = 11.
- Timeout: TIMEOUT=16, fetch PCs always distinct. Expect timed_out=1, halted=0, cycle_count=16, pass=0 even with all channels matching.
- Simultaneous events: TIMEOUT=16, HALT_REPEAT=2, second same-PC fetch on RUN cycle 15. Expect halted=1, timed_out=0, cycle_count=16.
- Reset mid-run: reset_n low asynchronously at RUN cycle 7, off-edge. Expect all outputs 0 immediately, state IDLE, and that start works again after reset_n rises.
- Restart and ignored start: start held during RUN has no effect. start in DONE clears fail_mask, snap_data and counters on the next edge, with busy=1 and done=0.

Source files
------------

// File: rtl/cpu_run_monitor_pkg.sv
// rtl/cpu_run_monitor_pkg.sv - state encoding and slice helper shared by cpu_run_monitor
package cpu_run_monitor_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_RUN     = RUN,
    ST_CAPTURE = CAPTURE,
    ST_DONE    = DONE
  } state_t;

  function automatic int unsigned slice_base(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cpu_run_monitor_check_lane.sv
// rtl/cpu_run_monitor_check_lane.sv - one register check channel: snapshot and mismatch flag
module check_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  capture,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] golden,
  output logic [DATA_WIDTH-1:0] snap,
  output logic                  mismatch
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap     <= '0;
      mismatch <= 1'b0;
    end else if (clear) begin
      snap     <= '0;
      mismatch <= 1'b0;
    end else if (capture) begin
      snap     <= data;
      mismatch <= enable && (data != golden);
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run controller: cycle/instruction counting, halt and timeout detection, result check
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int CYCLE_WIDTH = 17,
  parameter int TIMEOUT     = 4096,
  parameter int HALT_REPEAT = 2,
  parameter int NUM_CHECKS  = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             fetch_valid,
  input  logic [ADDR_WIDTH-1:0]            fetch_pc,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_data,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_expect,
  input  logic [NUM_CHECKS-1:0]            chk_enable,
  output logic                             busy,
  output logic                             done,
  output logic                             halted,
  output logic                             timed_out,
  output logic                             pass,
  output logic [NUM_CHECKS-1:0]            fail_mask,
  output logic [CYCLE_WIDTH-1:0]           cycle_count,
  output logic [CYCLE_WIDTH-1:0]           instr_count,
  output logic [NUM_CHECKS*DATA_WIDTH-1:0] snap_data
);

  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam logic [CYCLE_WIDTH-1:0] LAST_CYCLE = CYCLE_WIDTH'(TIMEOUT - 1);
  localparam logic [RW-1:0]          HALT_N     = RW'(HALT_REPEAT);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic [RW-1:0]         repeat_cnt, repeat_nx;
  logic                  pc_seen;
  logic                  launch, halt_hit, timeout_hit;

  always_comb begin
    state_nx    = state;
    launch      = 1'b0;
    halt_hit    = 1'b0;
    timeout_hit = 1'b0;
    repeat_nx   = (pc_seen && fetch_pc == last_pc) ? repeat_cnt + 1'b1 : RW'(1);
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_RUN;
          launch   = 1'b1;
        end
      end
      ST_RUN: begin
        // halt has priority over a timeout landing on the same edge
        halt_hit    = fetch_valid && (repeat_nx == HALT_N);
        timeout_hit = !halt_hit && (cycle_count == LAST_CYCLE);
        if (halt_hit || timeout_hit) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: state_nx = ST_DONE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      instr_count <= '0;
      last_pc     <= '0;
      repeat_cnt  <= '0;
      pc_seen     <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        cycle_count <= '0;
        instr_count <= '0;
        repeat_cnt  <= '0;
        pc_seen     <= 1'b0;
        halted      <= 1'b0;
        timed_out   <= 1'b0;
      end else if (state == ST_RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        if (fetch_valid) begin
          if (instr_count != '1) instr_count <= instr_count + 1'b1;
          last_pc    <= fetch_pc;
          repeat_cnt <= repeat_nx;
          pc_seen    <= 1'b1;
        end
        if (halt_hit)    halted    <= 1'b1;
        if (timeout_hit) timed_out <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_lane
    localparam int unsigned BASE = slice_base(i, DATA_WIDTH);
    check_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (launch),
      .capture  (state == ST_CAPTURE),
      .enable   (chk_enable[i]),
      .data     (chk_data[BASE +: DATA_WIDTH]),
      .golden   (chk_expect[BASE +: DATA_WIDTH]),
      .snap     (snap_data[BASE +: DATA_WIDTH]),
      .mismatch (fail_mask[i])
    );
  end

  assign busy = (state == ST_RUN) || (state == ST_CAPTURE);
  assign done = (state == ST_DONE);
  assign pass = done && halted && !(|fail_mask);

endmodule
